// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC/load-enable generation and the IF/EX instruction register.
// Optional HALT state enabled by defining FETCH_HALT_EN.
module fetch_stage #(
`ifdef FETCH_HALT_EN
  parameter logic [3:0] HALT_OP = 4'b1111,
`endif
  parameter int AW = 4,
  parameter int IW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [IW-1:0] rom_data,
  input  logic          stall,
  input  logic          jump_req,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] pc_next,
  output logic          pc_load,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  output logic [7:0]    fetch_cnt
);

  typedef enum logic [1:0] {
    ST_START,
    ST_FETCH
`ifdef FETCH_HALT_EN
    , ST_HALT
`endif
  } state_t;

  localparam logic [AW-1:0] PC_ONE = AW'(1);

  state_t        state_reg, state_next;
  logic [IW-1:0] ir_reg, ir_next;
  logic [AW-1:0] ir_pc_reg, ir_pc_next;
  logic          valid_reg, valid_next;
  logic [7:0]    cnt_reg, cnt_next;

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    ir_pc_next = ir_pc_reg;
    valid_next = valid_reg;
    cnt_next   = cnt_reg;
    pc_next    = '0;
    pc_load    = 1'b0;

    case (state_reg)
      ST_START: begin
        state_next = ST_FETCH;
        valid_next = 1'b0;
      end
      ST_FETCH: begin
        // Address arithmetic is AW bits wide, so pc+1 wraps naturally.
        pc_next = jump_req ? jump_addr : pc + PC_ONE;
        pc_load = jump_req | ~stall;
        if (jump_req) begin
          valid_next = 1'b0;
        end else if (!stall) begin
          ir_next    = rom_data;
          ir_pc_next = pc;
          valid_next = 1'b1;
          cnt_next   = cnt_reg + 8'd1;
`ifdef FETCH_HALT_EN
          if (rom_data[IW-1:IW-4] == HALT_OP) state_next = ST_HALT;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: begin
        pc_next    = pc;
        pc_load    = 1'b0;
        valid_next = 1'b0;
      end
`endif
      default: state_next = ST_START;
    endcase

    // PC register must see a quiet, zeroed interface while reset is held.
    if (reset) begin
      pc_next = '0;
      pc_load = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_START;
      ir_reg    <= '0;
      ir_pc_reg <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      ir_pc_reg <= ir_pc_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign ir        = ir_reg;
  assign ir_pc     = ir_pc_reg;
  assign ir_valid  = valid_reg;
  assign fetch_cnt = cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: environment PC register + ROM, reference model feeding a
// per-cycle scoreboard that a separate monitor drains after each rising edge.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam int AW = 4;
  localparam int IW = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          jump_req = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [AW-1:0] pc_r;
  logic [IW-1:0] rom_data;
  logic [AW-1:0] pc_next;
  logic          pc_load;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic [7:0]    fetch_cnt;
  logic [IW-1:0] rom [DEPTH];

  fetch_stage dut (
    .clock(clock), .reset(reset), .pc(pc_r), .rom_data(rom_data),
    .stall(stall), .jump_req(jump_req), .jump_addr(jump_addr),
    .pc_next(pc_next), .pc_load(pc_load), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clock = ~clock;

  // Environment: the PC register the stage drives, and a combinational ROM.
  always @(posedge clock) begin
    if (reset) pc_r <= '0;
    else if (pc_load) pc_r <= pc_next;
  end
  assign rom_data = rom[pc_r];

  typedef struct {
    int ir;
    int ir_pc;
    int valid;
    int cnt;
    int pc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 = start, 1 = fetching, 2 = halted
  int m_state = 0;
  int m_pc = 0, m_ir = 0, m_irpc = 0, m_valid = 0, m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit j, input int ja);
    exp_t e;
    int exp_load;
    @(negedge clock);
    reset = r;
    stall = s;
    jump_req = j;
    jump_addr = AW'(ja);
    #1;
    exp_load = (!r && m_state == 1) ? int'(j || !s) : 0;
    check("pc_load", {31'd0, pc_load}, exp_load);
    if (r)
      check("pc_next_reset", {28'd0, pc_next}, 0);
    else if (m_state == 1 && exp_load == 1)
      check("pc_next", {28'd0, pc_next}, j ? ja : (m_pc + 1) % DEPTH);
    else if (m_state == 2)
      check("pc_next_halt", {28'd0, pc_next}, m_pc);

    if (r) begin
      m_state = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_state = 1;
      m_valid = 0;
    end else if (m_state == 1) begin
      if (j) begin
        m_valid = 0;
        m_pc = ja;
      end else if (!s) begin
        m_ir = int'(rom[m_pc]);
        m_irpc = m_pc;
        m_valid = 1;
        m_cnt = (m_cnt + 1) % 256;
`ifdef FETCH_HALT_EN
        if ((m_ir / 16) == 15) m_state = 2;
`endif
        if (m_state == 1) m_pc = (m_pc + 1) % DEPTH;
      end
    end else begin
      m_valid = 0;
    end
    e.ir = m_ir; e.ir_pc = m_irpc; e.valid = m_valid; e.cnt = m_cnt; e.pc = m_pc;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per clock, compared just after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ir_valid", {31'd0, ir_valid}, e.valid);
      check("ir", {24'd0, ir}, e.ir);
      check("ir_pc", {28'd0, ir_pc}, e.ir_pc);
      check("fetch_cnt", {24'd0, fetch_cnt}, e.cnt);
      check("pc", {28'd0, pc_r}, e.pc);
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'(8'h10 + i);
    rom[4] = 8'hF0;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);   // includes 15 -> 0 wrap
    cycle(0, 0, 1, 9);                                // jump
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);    // stall
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 2);                                // jump beats stall
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);                                // mid-stream reset
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(99) < 2, $urandom_range(99) < 20,
            $urandom_range(99) < 12, int'($urandom_range(DEPTH - 1)));

    @(negedge clock);
    reset = 1'b0; stall = 1'b0; jump_req = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
